// File: rtl/accum4_sequencer.sv
// Batch accumulator: sums NUM_OPS 4-bit two's-complement operands through a ripple adder.
// Latency: out_valid rises the cycle after the last operand is accepted.
// Backpressure: in_ready drops while the result is held; the result waits for out_ready.
// Optional build macro ACCUM4_SATURATE_EN clamps the total on signed overflow instead of wrapping.
module accum4_sequencer #(
  parameter int NUM_OPS = 4,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_sum,
  output logic             out_carry,
  output logic             out_overflow,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS);

  state_e           state_q, state_d;
  logic             alive_q, alive_d;
  logic [3:0]       acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             done;
  logic [CNT_W-1:0] cnt_inc;

  logic [4:0]       rc;
  logic [3:0]       add_s;
  logic             add_c;
  logic             add_v;
  logic [3:0]       acc_load;

  // Four full adders chained on the carry; must settle within one clk period.
  assign rc[0] = 1'b0;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign add_s[i]  = acc_q[i] ^ in_data[i] ^ rc[i];
    assign rc[i+1]   = (acc_q[i] & in_data[i]) | (rc[i] & (acc_q[i] ^ in_data[i]));
  end
  assign add_c = rc[4];
  assign add_v = (acc_q[3] == in_data[3]) & (add_s[3] != acc_q[3]);

`ifdef ACCUM4_SATURATE_EN
  assign acc_load = add_v ? (acc_q[3] ? 4'b1000 : 4'b0111) : add_s;
`else
  assign acc_load = add_s;
`endif

  assign accept  = in_valid & in_ready;
  assign done    = out_valid & out_ready;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
      acc_q   <= 4'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= alive_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // clr outranks both an operand accept and a result handshake.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: if (accept) state_d = (cnt_inc == LAST_CNT) ? HOLD : ACCUM;
        HOLD:        if (done)   state_d = IDLE;
        default:     state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready     = alive_q & (state_q != HOLD);
    out_valid    = (state_q == HOLD);
    out_sum      = acc_q;
    out_carry    = carry_q;
    out_overflow = ovf_q;
    out_count    = cnt_q;
  end

  always_comb begin
    alive_d = 1'b1;
    acc_d   = acc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (clr || done) begin
      acc_d   = 4'b0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else if (accept) begin
      acc_d   = acc_load;
      carry_d = carry_q | add_c;
      ovf_d   = ovf_q | add_v;
      cnt_d   = cnt_inc;
    end
  end

endmodule

// File: tb/tb_accum4_sequencer.sv
// Bench for accum4_sequencer: directed batches plus random traffic against an arithmetic model.
module tb_accum4_sequencer;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       out_carry;
  logic       out_overflow;
  logic [3:0] out_count;

  accum4_sequencer #(.NUM_OPS(N), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .out_overflow(out_overflow), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int m_acc, m_cnt;
  bit m_c, m_v, m_hold, m_alive;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_acc = 0; m_cnt = 0; m_c = 0; m_v = 0; m_hold = 0;
  endtask

  function automatic int to_signed4(input int x);
    return (x > 7) ? x - 16 : x;
  endfunction

  // Behaviour at the coming rising edge, from the inputs currently driven.
  task automatic model_edge();
    bit rdy;
    int raw, r;
    rdy = m_alive && !m_hold;
    if (clr) model_clear();
    else if (m_hold) begin
      if (out_ready) model_clear();
    end else if (in_valid && rdy) begin
      raw = m_acc + int'(in_data);
      r   = to_signed4(m_acc) + to_signed4(int'(in_data));
      m_c = m_c | (raw > 15);
      m_v = m_v | (r > 7 || r < -8);
`ifdef ACCUM4_SATURATE_EN
      if (r > 7) m_acc = 7;
      else if (r < -8) m_acc = 8;
      else m_acc = raw % 16;
`else
      m_acc = raw % 16;
`endif
      m_cnt++;
      if (m_cnt == N) m_hold = 1;
    end
    m_alive = 1;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".in_ready"},  in_ready,     m_alive && !m_hold);
    chk({tag, ".out_valid"}, out_valid,    m_hold);
    chk({tag, ".sum"},       out_sum,      m_acc);
    chk({tag, ".carry"},     out_carry,    m_c);
    chk({tag, ".ovf"},       out_overflow, m_v);
    chk({tag, ".count"},     out_count,    m_cnt);
  endtask

  task automatic step(input string tag, input bit v, input int d, input bit c, input bit ordy);
    in_valid  = v;
    in_data   = 4'(d);
    clr       = c;
    out_ready = ordy;
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  // Four back-to-back operands, one cycle of result backpressure, then handshake.
  task automatic batch(input string tag, input int a, input int b, input int c, input int d,
                       input int exp_sum, input bit exp_c, input bit exp_v);
    step(tag, 1, a, 0, 0);
    step(tag, 1, b, 0, 0);
    step(tag, 1, c, 0, 0);
    step(tag, 1, d, 0, 0);
    chk({tag, ".fix_valid"}, out_valid, 1);
    chk({tag, ".fix_sum"},   out_sum, exp_sum);
    chk({tag, ".fix_carry"}, out_carry, exp_c);
    chk({tag, ".fix_ovf"},   out_overflow, exp_v);
    chk({tag, ".fix_count"}, out_count, 4);
    step(tag, 0, 0, 0, 0);
    step(tag, 0, 0, 0, 1);
    chk({tag, ".after_valid"}, out_valid, 0);
    chk({tag, ".after_rdy"},   in_ready, 1);
  endtask

  initial begin
    rst_n = 0; clr = 0; in_valid = 0; in_data = 0; out_ready = 0;
    model_clear();
    m_alive = 0;
    #12;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1;
    #1;
    compare_all("rel_pre_edge");
    step("first_edge", 0, 0, 0, 0);
    chk("first_edge.fix_rdy", in_ready, 1);

    batch("b2311", 2, 3, 1, 1, 4'b0111, 0, 0);
`ifdef ACCUM4_SATURATE_EN
    batch("b7700", 7, 7, 0, 0, 4'b0111, 0, 1);
`else
    batch("b7700", 7, 7, 0, 0, 4'b1110, 0, 1);
`endif
    batch("bm4m4", 12, 12, 0, 0, 4'b1000, 1, 0);

    // Result backpressure with an eager upstream.
    for (int i = 0; i < 4; i++) step("bp_fill", 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step("bp_hold", 1, 5, 0, 0);
      chk("bp_hold.fix_sum", out_sum, 4);
    end
    step("bp_release", 0, 0, 0, 1);
    chk("bp_release.fix_count", out_count, 0);

    // Mid-batch abort with a simultaneous operand.
    step("abort", 1, 3, 0, 1);
    step("abort", 1, 3, 0, 1);
    step("abort_clr", 1, 1, 1, 1);
    chk("abort.fix_count", out_count, 0);
    chk("abort.fix_sum", out_sum, 0);
    batch("b1111", 1, 1, 1, 1, 4'b0100, 0, 0);

    // Asynchronous reset between edges after two accepts.
    step("rst_mid", 1, 2, 0, 0);
    step("rst_mid", 1, 6, 0, 0);
    in_valid = 0;
    #3;
    rst_n = 0;
    #1;
    model_clear();
    m_alive = 0;
    compare_all("rst_low");
    #2;
    rst_n = 1;
    #1;
    compare_all("rst_rel");
    step("rst_edge", 0, 0, 0, 0);
    chk("rst_edge.fix_rdy", in_ready, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 15),
           $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/accum4_sequencer.md
Name: accum4_sequencer

Overview:
- Sequential downstream stage for the team's 4-bit two's-complement ripple adder.
- Accepts a batch of NUM_OPS 4-bit operands over a valid/ready handshake and adds each one into a running total through an internal 4-bit ripple adder.
- Registers the running total plus sticky carry-out and signed-overflow flags.
- Presents the batch result on a valid/ready output port; operands pass in for accumulation, and the result goes out to the next stage.

Parameters:
- NUM_OPS, 4, operands per batch; legal range 2..15.
- CNT_W, 4, width of the operand counter; must satisfy 2**CNT_W > NUM_OPS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort/clear of the current batch.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand.
- in_data  input  4  two's-complement operand.
- out_valid  output  1  batch result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  4  accumulated two's-complement total.
- out_carry  output  1  sticky OR of adder carry-out over the batch.
- out_overflow  output  1  sticky OR of signed overflow over the batch.
- out_count  output  CNT_W  operands accepted in the current batch.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - Accumulator, out_sum, out_carry, out_overflow and out_count are 0.
  - out_valid=0 and in_ready=0 while rst_n is low.
  - in_ready rises on the first clock edge after rst_n deasserts.
- States:
  - IDLE: count=0.
  - ACCUM: 0<count<NUM_OPS.
  - HOLD: result presented.
- in_ready=1 in IDLE and ACCUM; in_ready=0 in HOLD.
- An operand is accepted on a rising edge where in_valid & in_ready.
- Per accepted operand:
  - {c,s} = acc + in_data, computed unsigned as a 5-bit value.
  - acc <= s, so the total wraps mod 16.
  - carry_flag |= c.
  - Signed overflow v = (acc[3]==in_data[3]) & (s[3]!=acc[3]); ovf_flag |= v.
  - count <= count+1.
- Transitions:
  - IDLE->ACCUM on the first accept.
  - ACCUM->HOLD on the accept that makes count==NUM_OPS.
  - Latency: out_valid=1 on the cycle after the last operand is accepted.
- HOLD:
  - out_sum, out_carry, out_overflow and out_count stay stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: next state is IDLE; acc, flags and count clear to 0; out_valid=0 next cycle.
  - in_ready returns to 1 on that same next cycle.
  - The earliest next-batch accept is one cycle after the result handshake; no result/operand overlap.
- out_sum, out_carry, out_overflow and out_count track the registered values in every state, so partial totals are visible during ACCUM.
- clr=1 (synchronous):
  - Next state is IDLE; acc, flags and count clear; out_valid drops.
  - clr has priority over an operand accept and over a result handshake in the same cycle; neither takes effect.
- in_valid while in HOLD: ignored, because in_ready=0. The upstream stage must hold its data.
- Wrap-around: the sum wraps mod 16 without the optional feature. Carry and overflow are independent (e.g. -4 + -4 gives carry=1, overflow=0).
- Adder timing: the internal adder is combinational, so its ripple delay must settle within one clk period.

Optional Feature:
- Macro: ACCUM4_SATURATE_EN.
- Defined: when an add produces v=1, acc is loaded with 4'b0111 if acc[3]==0, else 4'b1000, instead of s. ovf_flag is still set. carry_flag is still updated from c.
- Undefined: acc always loads s (plain wrap). The ports are identical in both builds.

Test Plan:
- NUM_OPS=4, operands 2,3,1,1 back-to-back -> out_valid exactly one cycle after the 4th accept; out_sum=0111, carry=0, overflow=0, count=4.
- Operands 7,7,0,0:
  - Wrap build -> out_sum=1110 (-2), overflow=1, carry=0.
  - ACCUM4_SATURATE_EN build -> out_sum=0111, overflow=1.
- Operands -4,-4,0,0 -> out_sum=1000 (-8), carry=1, overflow=0.
- Result backpressure:
  - Stimulus: complete a batch, hold out_ready=0 for 5 cycles while driving in_valid=1 with data 5.
  - Required: in_ready=0 throughout, outputs stable, no operand accepted.
  - Then out_ready=1 -> out_valid=0 and in_ready=1 next cycle; acc=0, count=0.
- Mid-batch abort:
  - Stimulus: accept 3,3; then assert clr together with in_valid=1 (data 1).
  - Required: operand not accepted; next cycle count=0, out_sum=0, state IDLE.
  - A following batch of 1,1,1,1 -> out_sum=0100.
- Reset mid-batch:
  - Stimulus: after 2 accepts, pulse rst_n low asynchronously between clock edges.
  - Required: all outputs 0 immediately, in_ready=0 while low, in_ready=1 after the first edge post-release.
